// File: rtl/tb4004_pkg.sv
// Shared 4004 definitions: instruction-cycle phase codes and the step controller state set.
package tb4004_pkg;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_STEP
  } state_e;

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    return ph + 3'd1;
  endfunction

  function automatic logic is_cycle_end(input logic [2:0] ph);
    return ph == PH_X3;
  endfunction

endpackage

// File: rtl/fall_edge_sync.sv
// Two-flop synchroniser plus edge register; emits a one-cycle pulse on a falling edge of in.
module fall_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic vld_q;
  logic armed_q;

  // Detection is armed only after a genuine high input has been sampled, so a button
  // held down through reset cannot look like a 1->0 transition of the reset-high flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= 1'b1;
      armed_q <= armed_q | (vld_q & sync1_q);
    end
  end

  assign pulse = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// 4004 execution-clock controller: run/stop and single-step into ce pulses with phase tracking.
// Build option CPU_STEP_PHASE_EN: a step issues a single ce instead of a full instruction cycle.
module cpu_step_ctrl
  import tb4004_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step_n,
  output logic       ce,
  output logic [2:0] phase,
  output logic       sync,
  output logic       busy
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ce_q, ce_d;
  logic [2:0]  phase_q, phase_d;
  logic        sync_q, sync_d;
  logic        step_req;
  logic        step_done;
  logic        drain_done;
  logic        active;

  fall_edge_sync u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .in    (step_n),
    .pulse (step_req)
  );

  assign drain_done = ce_q && is_cycle_end(phase_q);

`ifdef CPU_STEP_PHASE_EN
  assign step_done = ce_q;
`else
  assign step_done = drain_done;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (drain_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler keeps counting across RUN/DRAIN/STEP hand-overs so ce cadence never slips;
  // it holds at zero in IDLE and clears on the edge that enters IDLE.
  always_comb begin
    active = (state_q != ST_IDLE) && (state_d != ST_IDLE);
    cnt_d  = '0;
    ce_d   = 1'b0;
    if (active) begin
      if (cnt_q == LAST) begin
        ce_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    phase_d = ce_q ? next_phase(phase_q) : phase_q;
    sync_d  = is_cycle_end(phase_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      phase_q <= PH_A1;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign ce    = ce_q;
  assign phase = phase_q;
  assign sync  = sync_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl (DIV=4): stimulus queues expected ce events, monitor pops.
`timescale 1ns/1ps
module tb_cpu_step_ctrl;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       step_n;
  logic       ce;
  logic [2:0] phase;
  logic       sync;
  logic       busy;

  cpu_step_ctrl #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .step_n (step_n),
    .ce     (ce),
    .phase  (phase),
    .sync   (sync),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic       sy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Queue ce events k=first..last: cycle base+DIV*k, phase (ph0+k) mod 8, sync on phase 7.
  task automatic push_ce(input int base, input int first, input int last, input int ph0);
    exp_t e;
    for (int k = first; k <= last; k++) begin
      e.cyc = base + int'(DIV) * k;
      e.ph  = 3'((ph0 + k) % 8);
      e.sy  = (((ph0 + k) % 8) == 7);
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ce === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ce: ce=1 at cycle %0d phase %0d, none required", cyc, phase);
      end else begin
        e = sb.pop_front();
        check("ce_cycle", cyc, e.cyc);
        check("ce_phase", phase, e.ph);
        check("ce_sync", sync, e.sy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int s;

    // Reset with the step button held down.
    rst    = 1'b1;
    run    = 1'b0;
    step_n = 1'b0;
    wait_cyc(3);
    check("rst_ce", ce, 0);
    check("rst_phase", phase, 0);
    check("rst_sync", sync, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_cyc(100);
    check("held_btn_busy", busy, 0);
    check("held_btn_phase", phase, 0);
    step_n = 1'b1;
    wait_cyc(10);
    check("release_btn_busy", busy, 0);

    // Free run, then drop run at phase 2 and drain to the cycle boundary.
    n   = cyc;
    run = 1'b1;
    push_ce(n + 5, 0, 15, 0);
    wait_until(n + 20);
    check("run_busy", busy, 1);
    wait_until(n + 42);
    check("phase_at_drop", phase, 2);
    run = 1'b0;
    wait_until(n + 67);
    check("drain_idle_busy", busy, 0);
    check("drain_idle_phase", phase, 0);
    check("drain_idle_sync", sync, 0);

    // Enter DRAIN early, re-raise run at phase 5, later drain from phase 0.
    m   = cyc;
    run = 1'b1;
    push_ce(m + 5, 0, 15, 0);
    wait_until(m + 6);
    run = 1'b0;
    wait_until(m + 22);
    check("phase_at_rerun", phase, 5);
    check("drain_busy", busy, 1);
    run = 1'b1;
    wait_until(m + 34);
    run = 1'b0;
    wait_until(m + 67);
    check("rerun_idle_busy", busy, 0);
    check("rerun_idle_phase", phase, 0);

`ifdef CPU_STEP_PHASE_EN
    // Each press yields one ce and IDLE keeps the advanced phase.
    for (int p = 0; p < 3; p++) begin
      s      = cyc;
      step_n = 1'b0;
      push_ce(s + 7, 0, 0, p);
      wait_until(s + 10);
      step_n = 1'b1;
      wait_until(s + 20);
      check("pstep_busy", busy, 0);
      check("pstep_phase", phase, p + 1);
    end
`else
    // Single step covers a full instruction cycle; a second press mid-step is ignored.
    s      = cyc;
    step_n = 1'b0;
    push_ce(s + 7, 0, 7, 0);
    wait_until(s + 10);
    step_n = 1'b1;
    wait_until(s + 14);
    step_n = 1'b0;
    wait_until(s + 20);
    step_n = 1'b1;
    wait_until(s + 24);
    check("step_busy", busy, 1);
    wait_until(s + 40);
    check("step_idle_busy", busy, 0);
    check("step_idle_phase", phase, 0);

    // Reset while the phase-4 ce of a step is in flight.
    s      = cyc;
    step_n = 1'b0;
    push_ce(s + 7, 0, 3, 0);
    wait_until(s + 10);
    step_n = 1'b1;
    wait_until(s + 23);
    check("inflight_ce", ce, 1);
    check("inflight_phase", phase, 4);
    rst = 1'b1;
    #1;
    check("abort_ce", ce, 0);
    check("abort_phase", phase, 0);
    check("abort_sync", sync, 0);
    check("abort_busy", busy, 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(30);
    check("post_abort_busy", busy, 0);
    check("post_abort_phase", phase, 0);
`endif

    wait_cyc(20);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
